// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared defaults, FSM state type and id-width helper for serial_add_sched
package serial_add_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Index width that never collapses to zero bits.
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational one-bit full adder, the single shared arithmetic resource
//   a_i, b_i, c_i  operand bits and carry-in
//   sum_o, carry_o sum bit and carry-out
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_sched.sv
// serial_add_sched: arbitrates NREQ requesters onto one full-adder cell, bit-serial add
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester request and one-hot acceptance pulse
//   req_a/req_b/req_cin     packed operands (requester i at [i*WIDTH +: WIDTH]) and carry-ins
//   res_valid/res_ready     result handshake
//   res_sum/res_cout/res_id registered result and id of the served requester
//   busy                    high whenever the FSM is not IDLE
// Macro SERIAL_ADD_RR_EN: round-robin arbitration; undefined gives fixed lowest-index priority.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int IDW   = id_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_cout,
    output logic [IDW-1:0]        res_id,
    output logic                  busy
);

    localparam int CW = id_w(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   win;
    logic             found;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    genvar g;
    for (g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

`ifdef SERIAL_ADD_RR_EN
    logic [IDW-1:0] ptr_q, ptr_d;

    // Search starts at ptr and wraps, so the last winner gets the lowest priority.
    always_comb begin : arb
        int j;
        logic [IDW-1:0] idx;
        j     = 0;
        idx   = '0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            j   = int'(ptr_q) + i;
            j   = (j >= NREQ) ? j - NREQ : j;
            idx = IDW'(j);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign ptr_d = (state_q == IDLE && found)
                 ? ((win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1))
                 : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin : arb
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found = 1'b1;
                win   = IDW'(i);
            end
        end
    end
`endif

    fa_cell u_fa (
        .a_i    (a_q[cnt_q]),
        .b_i    (b_q[cnt_q]),
        .c_i    (carry_q),
        .sum_o  (fa_s),
        .carry_o(fa_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        id_d    = id_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = SHIFT;
                a_d     = a_arr[win];
                b_d     = b_arr[win];
                carry_d = req_cin[win];
                id_d    = win;
                cnt_d   = '0;
                sum_d   = '0;
                cout_d  = 1'b0;
            end
            SHIFT: begin
                sum_d[cnt_q] = fa_s;
                carry_d      = fa_c;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    cout_d  = fa_c;
                    cnt_d   = '0;
                end
            end
            DONE: state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
        end
    end

    // Gated by rst_n so every output reads 0 while reset is held, even with requests pending.
    assign req_ready = (state_q == IDLE && found && rst_n) ? (NREQ'(1) << win) : '0;
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// tb_serial_add_sched: scoreboard bench for serial_add_sched (NREQ=4, WIDTH=8)
module tb_serial_add_sched;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_cin = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [W-1:0]   res_sum;
    logic           res_cout;
    logic [1:0]     res_id;
    logic           busy;

    typedef struct {
        logic [1:0] id;
        logic [W:0] val;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_add_sched #(.NREQ(N), .WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_cin  (req_cin),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_sum  (res_sum),
        .res_cout (res_cout),
        .res_id   (res_id),
        .busy     (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
        req_valid[i]    = 1'b1;
    endtask

    task automatic push_exp(input int i);
        exp_t e;
        e.id  = 2'(i);
        e.val = {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]} + {{W{1'b0}}, req_cin[i]};
        q.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        e.id  = 2'd3;
        e.val = '1;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty got=result exp=no_result");
        end else e = q.pop_front();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n     = 1'b0;
        req_valid = '1;
        tick();
        tick();
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
        end
        req_valid = '0;
        #1;
        checks++;
        if ({res_valid, res_sum, res_cout, res_id, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=v%b s%h c%b id%0d b%b exp=all_zero",
                     res_valid, res_sum, res_cout, res_id, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        e.id = 0;
    endtask

    task automatic test_all_four();
        exp_t e;
        int   mptr = 0;
        int   exp_id;
        int   got = 0;
        int   cyc = 0;
        for (int i = 0; i < N; i++) set_req(i, W'(8'h10 * i + 3), W'(8'h21 + i), i[0]);
        res_ready = 1'b1;
        #1;
        while (got < 5 && cyc < 200) begin
            if (req_ready != '0) begin
`ifdef SERIAL_ADD_RR_EN
                exp_id = mptr;
`else
                exp_id = 0;
`endif
                mptr = (exp_id + 1) % N;
                checks++;
                if (req_ready !== 4'(1 << exp_id)) begin
                    failures++;
                    $display("FAIL all4_grant got=%b exp=%b", req_ready, 4'(1 << exp_id));
                end
                push_exp(exp_id);
            end
            if (res_valid) begin
                pop_exp(e);
                checks++;
                if (res_id !== e.id || {res_cout, res_sum} !== e.val) begin
                    failures++;
                    $display("FAIL all4_result got=id%0d %h exp=id%0d %h", res_id, {res_cout, res_sum}, e.id, e.val);
                end
                got++;
            end
            tick();
            cyc++;
        end
        req_valid = '0;
        res_ready = 1'b0;
        checks++;
        if (got != 5 || q.size() != 0) begin
            failures++;
            $display("FAIL all4_count got=%0d pending=%0d exp=5 pending=0", got, q.size());
        end
        tick();
    endtask

    task automatic test_basic();
        int         ids[3] = '{0, 2, 1};
        logic [7:0] as[3]  = '{8'h0F, 8'hFF, 8'h7F};
        logic [7:0] bs[3]  = '{8'h01, 8'h01, 8'h80};
        logic       cs[3]  = '{1'b0, 1'b0, 1'b1};
        logic [8:0] es[3]  = '{9'h010, 9'h100, 9'h100};
        exp_t       e;
        int         n;
        for (int k = 0; k < 3; k++) begin
            set_req(ids[k], as[k], bs[k], cs[k]);
            #1;
            checks++;
            if (req_ready !== 4'(1 << ids[k])) begin
                failures++;
                $display("FAIL basic%0d_ready got=%b exp=%b", k, req_ready, 4'(1 << ids[k]));
            end
            e.id  = 2'(ids[k]);
            e.val = es[k];
            q.push_back(e);
            tick();
            req_valid = '0;
            checks++;
            if (busy !== 1'b1 || req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL basic%0d_busy got=%b/%b exp=1/0000", k, busy, req_ready);
            end
            wait_valid(n);
            checks++;
            if (n != W || res_valid !== 1'b1) begin
                failures++;
                $display("FAIL basic%0d_latency got=%0d exp=%0d", k, n, W);
            end
            pop_exp(e);
            checks++;
            if (res_id !== e.id || {res_cout, res_sum} !== e.val) begin
                failures++;
                $display("FAIL basic%0d_result got=id%0d %h exp=id%0d %h", k, res_id, {res_cout, res_sum}, e.id, e.val);
            end
            handshake();
            checks++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL basic%0d_release got=%b/%b exp=0/0", k, res_valid, busy);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int   n;
        set_req(0, 8'h3C, 8'h5A, 1'b1);
        push_exp(0);
        tick();
        req_valid = '0;
        wait_valid(n);
        pop_exp(e);
        set_req(1, 8'h11, 8'h22, 1'b0);
        set_req(2, 8'h33, 8'h44, 1'b1);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (res_valid !== 1'b1 || res_id !== e.id || {res_cout, res_sum} !== e.val || req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL stall_c%0d got=v%b id%0d %h rdy%b exp=v1 id%0d %h rdy0000",
                         c, res_valid, res_id, {res_cout, res_sum}, req_ready, e.id, e.val);
            end
            tick();
        end
        req_valid = '0;
        handshake();
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got=%b exp=0", res_valid);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n;
        set_req(2, 8'hAA, 8'h55, 1'b0);
        push_exp(2);
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, res_valid, res_sum, res_cout, res_id, busy} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=r%b v%b s%h c%b id%0d b%b exp=all_zero",
                     req_ready, res_valid, res_sum, res_cout, res_id, busy);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_req(1, 8'h40, 8'h22, 1'b0);
        set_req(3, 8'h01, 8'h02, 1'b0);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL midreset_ptr got=%b exp=0010", req_ready);
        end
        push_exp(1);
        tick();
        req_valid[1] = 1'b0;
        wait_valid(n);
        pop_exp(e);
        checks++;
        if (res_valid !== 1'b1 || res_id !== e.id || {res_cout, res_sum} !== e.val) begin
            failures++;
            $display("FAIL midreset_req1 got=v%b id%0d %h exp=v1 id%0d %h", res_valid, res_id, {res_cout, res_sum}, e.id, e.val);
        end
        handshake();
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL midreset_req3_ready got=%b exp=1000", req_ready);
        end
        e.id  = 2'd3;
        e.val = 9'h003;
        q.push_back(e);
        tick();
        req_valid = '0;
        wait_valid(n);
        pop_exp(e);
        checks++;
        if (res_valid !== 1'b1 || n != W || res_id !== e.id || {res_cout, res_sum} !== e.val) begin
            failures++;
            $display("FAIL midreset_req3 got=v%b lat%0d id%0d %h exp=v1 lat%0d id%0d %h",
                     res_valid, n, res_id, {res_cout, res_sum}, W, e.id, e.val);
        end
        handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_four();
        test_basic();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
